// File: rtl/sync_fifo.sv
// Single-clock FIFO, 2**ADDR_WIDTH words deep, with level flags, used-word count
// and a choice of registered or show-ahead read data.
module sync_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int AFULL_LEVEL  = 248,
    parameter int AEMPTY_LEVEL = 8,
    parameter int LOOKAHEAD    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   uw
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] L_FULL   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_AFULL  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] L_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_uw;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    assign uw     = r_uw;
    assign empty  = (r_uw == '0);
    assign full   = (r_uw == L_FULL);
    assign afull  = (r_uw >= L_AFULL);
    assign aempty = (r_uw <= L_AEMPTY);

    always_ff @(posedge clk) begin
        if (w_wr_acc && !sclr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_uw     <= '0;
        end else if (sclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_uw     <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_uw <= r_uw + 1'b1;
                2'b01:   r_uw <= r_uw - 1'b1;
                default: r_uw <= r_uw;
            endcase
        end
    end

    generate
        if (LOOKAHEAD != 0) begin : g_showahead
            // Head word is shown directly; forced to zero while empty so reset reads 0.
            assign data_out = empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] r_dout;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (sclr) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end

            assign data_out = r_dout;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one registered-read and one show-ahead instance
// share stimulus and are compared against a queue model of the FIFO.
module tb_sync_fifo;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclr;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] data_out;
    logic          empty, full, afull, aempty;
    logic [AW:0]   uw;

    logic [DW-1:0] la_data_out;
    logic          la_empty, la_full, la_afull, la_aempty;
    logic [AW:0]   la_uw;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_dout;
    logic [DW-1:0] seq_data;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .AFULL_LEVEL (248),
        .AEMPTY_LEVEL(8),
        .LOOKAHEAD   (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclr    (sclr),
        .data_in (data_in),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .data_out(data_out),
        .empty   (empty),
        .full    (full),
        .afull   (afull),
        .aempty  (aempty),
        .uw      (uw)
    );

    sync_fifo #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .AFULL_LEVEL (248),
        .AEMPTY_LEVEL(8),
        .LOOKAHEAD   (1)
    ) dut_la (
        .clk     (clk),
        .rst     (rst),
        .sclr    (sclr),
        .data_in (data_in),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .data_out(la_data_out),
        .empty   (la_empty),
        .full    (la_full),
        .afull   (la_afull),
        .aempty  (la_aempty),
        .uw      (la_uw)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = m_q.size();
        check("uw", 32'(uw), 32'(sz));
        check("empty", 32'(empty), 32'(sz == 0));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("afull", 32'(afull), 32'(sz >= 248));
        check("aempty", 32'(aempty), 32'(sz <= 8));
        check("data_out", data_out, m_dout);
        check("la_uw", 32'(la_uw), 32'(sz));
        check("la_flags", 32'({la_empty, la_full, la_afull, la_aempty}),
              32'({sz == 0, sz == DEPTH, sz >= 248, sz <= 8}));
        if (sz > 0) begin
            check("la_head", la_data_out, m_q[0]);
        end
    endtask

    // Drives one cycle, then updates the model with what the FIFO must accept.
    task automatic step(input logic w, input logic r, input logic c);
        int   sz;
        logic wa, ra;
        sz = m_q.size();
        wa = w && (sz < DEPTH);
        ra = r && (sz > 0);
        wr_en   = w;
        rd_en   = r;
        sclr    = c;
        data_in = seq_data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        sclr  = 1'b0;
        if (c) begin
            m_q.delete();
            m_dout = '0;
        end else begin
            if (ra) m_dout = m_q.pop_front();
            if (wa) m_q.push_back(seq_data);
        end
        if (w) seq_data = seq_data + 32'h0101_0007;
        check_state();
    endtask

    initial begin
        rst      = 1'b1;
        sclr     = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = '0;
        m_dout   = '0;
        seq_data = 32'h1234_0000;

        // Reset while idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
        check("rst_data_out", data_out, 32'h0);
        check("rst_la_data_out", la_data_out, 32'h0);

        // 16 writes then 16 reads
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
        check("uw16", 32'(uw), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
        check("empty_after_drain", 32'(empty), 32'd1);

        // Read on empty: data_out must hold the last word read
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        check("hold_nonzero", 32'(data_out != 32'h0), 32'd1);

        // Simultaneous read+write at uw=5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        check("uw_rdwr", 32'(uw), 32'd5);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);

        // Fill to full, one overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 246) check("afull_247", 32'(afull), 32'd0);
            if (i == 247) check("afull_248", 32'(afull), 32'd1);
            if (i == 254) check("full_255", 32'(full), 32'd0);
        end
        check("full_256", 32'(full), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("overflow_uw", 32'(uw), 32'd256);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0);
        check("drained", 32'(uw), 32'd0);

        // 200-word bursts spanning more than two pointer wraps
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0);
        end

        // Synchronous clear at uw=16 overrides wr_en/rd_en
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("sclr_uw", 32'(uw), 32'd0);
        check("sclr_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-burst clears without a clock edge
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_uw", 32'(uw), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_data_out", data_out, 32'h0);
        check("arst_la_uw", 32'(la_uw), 32'd0);
        m_q.delete();
        m_dout = '0;
        #2;
        rst = 1'b0;

        // Show-ahead: head word visible before each rd_en
        step(1'b1, 1'b0, 1'b0);
        check("la_first_word", la_data_out, m_q[0]);
        for (int i = 1; i < 16; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("la_before_rd", la_data_out, m_q[0]);
            step(1'b0, 1'b1, 1'b0);
        end
        check("la_end_empty", 32'(la_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
